fpu_cvt_wb_queue: RTL and testbench

// - Downstream of the FP->INT convert unit in the low FPU cluster.
// - Captures each 65-bit convert result (FUCVT1) and its alt-path flag (daltX).
// - Tags each result with its destination and queues it for the integer writeback port using a valid/ready handshake.
// - The convert pipeline cannot stall mid-flight, so the block asserts issue back-pressure early (almost-full).

---
 rtl/fpu_cvt_wb_pkg.sv | 9 +
 rtl/fpu_cvt_wb_ram.sv | 17 +
 rtl/fpu_cvt_wb_queue.sv | 67 ++++++
 tb/tb_fpu_cvt_wb_queue.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fpu_cvt_wb_pkg.sv
// fpu_cvt_wb_pkg: shared types for the convert-result writeback queue
package fpu_cvt_wb_pkg;
    localparam int CVT_TAG_W = 9;
    typedef struct packed {
        logic [64:0]          res;
        logic                 alt;
        logic [CVT_TAG_W-1:0] tag;
    } cvt_wb_ent_t;
endpackage

// File: rtl/fpu_cvt_wb_ram.sv
// fpu_cvt_wb_ram: DEPTH x W storage, one write port and one async read port, contents never reset
module fpu_cvt_wb_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 75
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fpu_cvt_wb_queue.sv
// fpu_cvt_wb_queue: queues FP->INT convert results for the integer writeback port,
// with registered head outputs and early issue back-pressure.
module fpu_cvt_wb_queue
    import fpu_cvt_wb_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AFULL_GAP = 2,
    parameter int TAG_W     = CVT_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cvt_vld,
    input  logic [64:0]      cvt_res,
    input  logic             cvt_alt,
    input  logic [TAG_W-1:0] cvt_tag,
    input  logic             flush,
    output logic             cvt_stall,
    output logic             wb_vld,
    input  logic             wb_rdy,
    output logic [64:0]      wb_res,
    output logic             wb_alt,
    output logic [TAG_W-1:0] wb_tag,
    output logic             ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int W  = 66 + TAG_W;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
    logic [W-1:0]  in_ent, rd_data, head;
    logic          full, pop, push;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = wb_vld && wb_rdy;
    assign push    = cvt_vld && (!full || pop) && !flush;
    assign rd_nxt  = flush ? '0 : rd_ptr + PW'(pop);
    assign wr_nxt  = flush ? '0 : wr_ptr + PW'(push);
    assign cnt_nxt = wr_nxt - rd_nxt;
    assign in_ent  = {cvt_res, cvt_alt, cvt_tag};
    // When the next head is the slot being written this cycle, bypass the incoming entry
    assign head    = (push && rd_nxt[AW-1:0] == wr_ptr[AW-1:0]) ? in_ent : rd_data;
    fpu_cvt_wb_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_ent),
        .raddr (rd_nxt[AW-1:0]),
        .rdata (rd_data)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wb_vld    <= 1'b0;
            wb_res    <= '0;
            wb_alt    <= 1'b0;
            wb_tag    <= '0;
            cvt_stall <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            wb_vld    <= cnt_nxt != '0;
            {wb_res, wb_alt, wb_tag} <= head;
            cvt_stall <= cnt_nxt >= PW'(DEPTH - AFULL_GAP);
            if (cvt_vld && full && !pop && !flush) ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpu_cvt_wb_queue.sv
// tb_fpu_cvt_wb_queue: directed plus randomized stimulus checked against a queue-based model
module tb_fpu_cvt_wb_queue;
    import fpu_cvt_wb_pkg::*;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    logic        clk = 0, rst = 0, cvt_vld = 0, cvt_alt = 0, flush = 0, wb_rdy = 0;
    logic [64:0] cvt_res = '0;
    logic [8:0]  cvt_tag = '0;
    logic        cvt_stall, wb_vld, wb_alt, ovf_err;
    logic [64:0] wb_res;
    logic [8:0]  wb_tag;
    cvt_wb_ent_t q[$];
    bit          m_ovf;
    int          checks, errors;

    fpu_cvt_wb_queue #(.DEPTH(DEPTH), .AFULL_GAP(GAP), .TAG_W(9)) dut (
        .clk(clk), .rst(rst), .cvt_vld(cvt_vld), .cvt_res(cvt_res), .cvt_alt(cvt_alt),
        .cvt_tag(cvt_tag), .flush(flush), .cvt_stall(cvt_stall), .wb_vld(wb_vld),
        .wb_rdy(wb_rdy), .wb_res(wb_res), .wb_alt(wb_alt), .wb_tag(wb_tag), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit pop, full;
        @(posedge clk);
        pop  = q.size() != 0 && wb_rdy;
        full = q.size() == DEPTH;
        if (!rst) begin
            q.delete();
            m_ovf = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (cvt_vld) begin
                if (!full || pop) q.push_back('{res: cvt_res, alt: cvt_alt, tag: cvt_tag});
                else m_ovf = 1;
            end
        end
        #1;
        chk("wb_vld", wb_vld, q.size() != 0);
        chk("cvt_stall", cvt_stall, q.size() >= DEPTH - GAP);
        chk("ovf_err", ovf_err, m_ovf);
        if (!rst) begin
            chk("rst_res", wb_res, 0);
            chk("rst_alt", wb_alt, 0);
            chk("rst_tag", wb_tag, 0);
        end else if (q.size() != 0) begin
            chk("wb_res", wb_res, q[0].res);
            chk("wb_alt", wb_alt, q[0].alt);
            chk("wb_tag", wb_tag, q[0].tag);
        end
    endtask

    task automatic cyc(input bit v, input bit r, input bit f, input logic [8:0] t);
        cvt_vld = v;
        wb_rdy  = r;
        flush   = f;
        cvt_tag = t;
        cvt_res = 65'({$urandom, $urandom, $urandom});
        cvt_alt = 1'($urandom);
        step();
    endtask

    initial begin
        rst = 0;
        step();
        step();
        rst = 1;
        // single push with immediate acceptance
        cvt_vld = 1; cvt_res = 65'h1_2345_6789_ABCD_EF01; cvt_tag = 9'h05A; cvt_alt = 0; wb_rdy = 1;
        step();
        chk("single_res", wb_res, 65'h1_2345_6789_ABCD_EF01);
        cvt_vld = 0;
        step();
        chk("single_gone", wb_vld, 0);
        // back-pressure then drain
        cyc(1, 0, 0, 9'h001);
        cyc(1, 0, 0, 9'h002);
        chk("bp_stall", cvt_stall, 1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 9'h0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 9'h0);
        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 9'(16 + i));
        cyc(1, 1, 0, 9'h0AA);
        chk("full_pp_ovf", ovf_err, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 9'h0);
        // overflow
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 9'(32 + i));
        cyc(1, 0, 0, 9'h1FF);
        chk("ovf_set", ovf_err, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 9'h0);
        // flush with a concurrent push
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 9'(48 + i));
        cyc(1, 0, 1, 9'h077);
        chk("flush_vld", wb_vld, 0);
        cyc(1, 1, 0, 9'h078);
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, 9'h0);
        // reset mid-drain, then push/pop across the wrap
        cyc(1, 0, 0, 9'h061);
        cyc(1, 0, 0, 9'h062);
        rst = 0;
        cyc(0, 1, 0, 9'h0);
        rst = 1;
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 9'($urandom));
        cyc(0, 1, 0, 9'h0);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(0, 99) != 0;
            cyc($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                $urandom_range(0, 39) == 0, 9'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
